// File: rtl/uart_rx_path_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_path_if
// Purpose  : Signal bundle between a serial-line / consumer environment and
//            the uart_rx_path receiver.
// Ports    : Rx, PF, ready_in          - environment -> receiver
//            data_out, valid_out,
//            parity_err, frame_err,
//            overrun, busy             - receiver -> environment
// Modports : master (environment side), slave (receiver side)
// Revision : 1.0 - initial release
// ============================================================================
interface uart_rx_path_if #(
    parameter int WIDTH_SIZE = 8
);
    logic                  Rx;
    logic                  PF;
    logic                  ready_in;
    logic [WIDTH_SIZE-1:0] data_out;
    logic                  valid_out;
    logic                  parity_err;
    logic                  frame_err;
    logic                  overrun;
    logic                  busy;

    modport master (
        output Rx, PF, ready_in,
        input  data_out, valid_out, parity_err, frame_err, overrun, busy
    );

    modport slave (
        input  Rx, PF, ready_in,
        output data_out, valid_out, parity_err, frame_err, overrun, busy
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_path.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_path
// Purpose  : Un-divided UART receiver (one line bit per clk). Frame is
//            start(0), WIDTH_SIZE data bits LSB first, even parity bit(s),
//            stop(1). PF=0: one parity bit after all data; PF=1: one parity
//            bit after every 8-bit group and after the final partial group.
//            Completed frames go to a single holding register with a
//            valid/ready handshake; a frame completing while the holder is
//            full and not being accepted is dropped and flagged by overrun.
// Ports    : clk          rising-edge clock
//            reset        asynchronous, active-low reset
//            bus (slave)  Rx, PF, ready_in in; data_out, valid_out,
//                         parity_err, frame_err, overrun, busy out
// Options  : UART_RX_SYNC_EN - insert a 2-flop synchroniser on Rx
//                              (adds 2 cycles to every Rx-related latency)
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_path #(
    parameter int WIDTH_SIZE = 8
) (
    input  wire logic       clk,
    input  wire logic       reset,
    uart_rx_path_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    // Index must hold WIDTH_SIZE itself: it marks "all payload bits taken".
    localparam int                IDX_W      = $clog2(WIDTH_SIZE + 1);
    localparam logic [IDX_W-1:0]  C_LAST_IDX = IDX_W'(WIDTH_SIZE - 1);
    localparam logic [IDX_W-1:0]  C_END_IDX  = IDX_W'(WIDTH_SIZE);

    state_t                state_q;
    logic [IDX_W-1:0]      idx_q;
    logic [2:0]            grp_q;       // position inside current 8-bit group
    logic                  pf_q;        // parity format frozen for the frame
    logic                  par_q;       // running parity of current coverage
    logic                  perr_q;      // any parity mismatch so far
    logic [WIDTH_SIZE-1:0] shift_q;
    logic [WIDTH_SIZE-1:0] shift_d;
    logic [WIDTH_SIZE-1:0] data_q;
    logic                  valid_q;
    logic                  perr_out_q;
    logic                  ferr_out_q;
    logic                  overrun_q;
    logic                  rx_smp;

    // ------------------------------------------------------------------
    // Line sampling
    // ------------------------------------------------------------------
`ifdef UART_RX_SYNC_EN
    logic [1:0] sync_q;

    // Flops reset to the idle level so release from reset never looks
    // like a start bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], bus.Rx};
        end
    end

    assign rx_smp = sync_q[1];
`else
    assign rx_smp = bus.Rx;
`endif

    // ------------------------------------------------------------------
    // Payload shifter: new bits enter at the MSB and move down, so after
    // WIDTH_SIZE shifts the first line bit sits at bit 0.
    // ------------------------------------------------------------------
    generate
        if (WIDTH_SIZE == 1) begin : g_shift_single
            assign shift_d = rx_smp;
        end else begin : g_shift_multi
            assign shift_d = {rx_smp, shift_q[WIDTH_SIZE-1:1]};
        end
    endgenerate

    // ------------------------------------------------------------------
    // Receive FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            grp_q      <= 3'd0;
            pf_q       <= 1'b0;
            par_q      <= 1'b0;
            perr_q     <= 1'b0;
            shift_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            overrun_q <= 1'b0;

            // Consumer accept; a completion below may re-set valid on
            // the same edge.
            if (valid_q && bus.ready_in) begin
                valid_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    if (!rx_smp) begin
                        state_q <= S_DATA;
                        pf_q    <= bus.PF;
                        idx_q   <= '0;
                        grp_q   <= 3'd0;
                        par_q   <= 1'b0;
                        perr_q  <= 1'b0;
                    end
                end

                S_DATA: begin
                    shift_q <= shift_d;
                    idx_q   <= idx_q + IDX_W'(1);
                    grp_q   <= grp_q + 3'd1;
                    par_q   <= par_q ^ rx_smp;
                    if ((idx_q == C_LAST_IDX) || (pf_q && (grp_q == 3'd7))) begin
                        state_q <= S_PARITY;
                    end
                end

                S_PARITY: begin
                    if (rx_smp != par_q) begin
                        perr_q <= 1'b1;
                    end
                    par_q   <= 1'b0;
                    grp_q   <= 3'd0;
                    state_q <= (idx_q == C_END_IDX) ? S_STOP : S_DATA;
                end

                S_STOP: begin
                    state_q <= S_IDLE;
                    if (!valid_q || bus.ready_in) begin
                        data_q     <= shift_q;
                        perr_out_q <= perr_q;
                        ferr_out_q <= ~rx_smp;
                        valid_q    <= 1'b1;
                    end else begin
                        overrun_q  <= 1'b1;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.data_out   = data_q;
    assign bus.valid_out  = valid_q;
    assign bus.parity_err = perr_out_q;
    assign bus.frame_err  = ferr_out_q;
    assign bus.overrun    = overrun_q;
    assign bus.busy       = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_path.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_path
// Purpose  : Directed self-checking bench for uart_rx_path, with an 8-bit
//            and a 16-bit receiver instance sharing clock and reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_path;

`ifdef UART_RX_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    uart_rx_path_if #(.WIDTH_SIZE(8))  if8 ();
    uart_rx_path_if #(.WIDTH_SIZE(16)) if16 ();

    uart_rx_path #(.WIDTH_SIZE(8)) dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (if8.slave)
    );

    uart_rx_path #(.WIDTH_SIZE(16)) dut16 (
        .clk   (clk),
        .reset (reset),
        .bus   (if16.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one line bit; it is sampled on the following rising edge.
    task automatic drv(input bit sel16, input logic b);
        @(negedge clk);
        if (sel16) if16.Rx = b;
        else       if8.Rx  = b;
    endtask

    // Return line to idle and advance to the first cycle after the stop
    // bit has reached the FSM.
    task automatic settle(input bit sel16);
        @(negedge clk);
        if (sel16) if16.Rx = 1'b1;
        else       if8.Rx  = 1'b1;
        repeat (SYNC_LAT) @(negedge clk);
    endtask

    task automatic send8(input logic [7:0] data, input logic pbit, input logic stop);
        drv(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) drv(1'b0, data[i]);
        drv(1'b0, pbit);
        drv(1'b0, stop);
    endtask

    task automatic send16(input logic [15:0] data, input logic pf,
                          input logic p0, input logic p1);
        if16.PF = pf;
        drv(1'b1, 1'b0);
        if (pf) begin
            for (int i = 0; i < 8; i++) drv(1'b1, data[i]);
            drv(1'b1, p0);
            for (int i = 8; i < 16; i++) drv(1'b1, data[i]);
            drv(1'b1, p1);
        end else begin
            for (int i = 0; i < 16; i++) drv(1'b1, data[i]);
            drv(1'b1, p0);
        end
        drv(1'b1, 1'b1);
    endtask

    task automatic test_reset;
        reset = 1'b0;
        if8.Rx = 1'b1;  if8.PF = 1'b0;  if8.ready_in = 1'b1;
        if16.Rx = 1'b1; if16.PF = 1'b0; if16.ready_in = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (if8.data_out !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected %h", if8.data_out, 8'h00); end
        checks++; if (if8.valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", if8.valid_out); end
        checks++; if (if8.parity_err !== 1'b0 || if8.frame_err !== 1'b0) begin errors++; $display("FAIL reset_errs: got p=%b f=%b expected 0 0", if8.parity_err, if8.frame_err); end
        checks++; if (if8.overrun !== 1'b0 || if8.busy !== 1'b0) begin errors++; $display("FAIL reset_ovr_busy: got o=%b b=%b expected 0 0", if8.overrun, if8.busy); end
        checks++; if (if16.valid_out !== 1'b0 || if16.busy !== 1'b0) begin errors++; $display("FAIL reset16: got v=%b b=%b expected 0 0", if16.valid_out, if16.busy); end
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic;
        send8(8'hA5, 1'b0, 1'b1);
        checks++; if (if8.valid_out !== 1'b0) begin errors++; $display("FAIL basic_valid_early: got %b expected 0", if8.valid_out); end
        checks++; if (if8.busy !== 1'b1) begin errors++; $display("FAIL basic_busy_mid: got %b expected 1", if8.busy); end
        settle(1'b0);
        checks++; if (if8.data_out !== 8'hA5) begin errors++; $display("FAIL basic_data: got %h expected %h", if8.data_out, 8'hA5); end
        checks++; if (if8.valid_out !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", if8.valid_out); end
        checks++; if (if8.parity_err !== 1'b0 || if8.frame_err !== 1'b0) begin errors++; $display("FAIL basic_errs: got p=%b f=%b expected 0 0", if8.parity_err, if8.frame_err); end
        checks++; if (if8.busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end: got %b expected 0", if8.busy); end
        @(negedge clk);
        checks++; if (if8.valid_out !== 1'b0) begin errors++; $display("FAIL basic_accept: got %b expected 0", if8.valid_out); end
    endtask

    task automatic test_parity_err;
        send8(8'hA5, 1'b1, 1'b1);
        settle(1'b0);
        checks++; if (if8.data_out !== 8'hA5) begin errors++; $display("FAIL perr_data: got %h expected %h", if8.data_out, 8'hA5); end
        checks++; if (if8.parity_err !== 1'b1 || if8.frame_err !== 1'b0) begin errors++; $display("FAIL perr_flags: got p=%b f=%b expected 1 0", if8.parity_err, if8.frame_err); end
        checks++; if (if8.valid_out !== 1'b1) begin errors++; $display("FAIL perr_valid: got %b expected 1", if8.valid_out); end
    endtask

    task automatic test_frame_err;
        send8(8'hA5, 1'b0, 1'b0);
        settle(1'b0);
        checks++; if (if8.data_out !== 8'hA5) begin errors++; $display("FAIL ferr_data: got %h expected %h", if8.data_out, 8'hA5); end
        checks++; if (if8.frame_err !== 1'b1 || if8.parity_err !== 1'b0) begin errors++; $display("FAIL ferr_flags: got f=%b p=%b expected 1 0", if8.frame_err, if8.parity_err); end
        // One idle cycle, then a clean frame.
        send8(8'h3C, 1'b0, 1'b1);
        settle(1'b0);
        checks++; if (if8.data_out !== 8'h3C) begin errors++; $display("FAIL ferr_next_data: got %h expected %h", if8.data_out, 8'h3C); end
        checks++; if (if8.frame_err !== 1'b0 || if8.parity_err !== 1'b0 || if8.valid_out !== 1'b1) begin errors++; $display("FAIL ferr_next_flags: got f=%b p=%b v=%b expected 0 0 1", if8.frame_err, if8.parity_err, if8.valid_out); end
    endtask

    task automatic test_pf_groups;
        // 0x13F1: low byte has 5 ones, high byte 3 ones -> P0=1, P1=1.
        send16(16'h13F1, 1'b1, 1'b1, 1'b1);
        settle(1'b1);
        checks++; if (if16.data_out !== 16'h13F1) begin errors++; $display("FAIL pf1_data: got %h expected %h", if16.data_out, 16'h13F1); end
        checks++; if (if16.parity_err !== 1'b0 || if16.valid_out !== 1'b1) begin errors++; $display("FAIL pf1_flags: got p=%b v=%b expected 0 1", if16.parity_err, if16.valid_out); end
        send16(16'h13F1, 1'b1, 1'b1, 1'b0);
        settle(1'b1);
        checks++; if (if16.data_out !== 16'h13F1) begin errors++; $display("FAIL pf1_bad_data: got %h expected %h", if16.data_out, 16'h13F1); end
        checks++; if (if16.parity_err !== 1'b1) begin errors++; $display("FAIL pf1_bad_perr: got %b expected 1", if16.parity_err); end
        // Whole-word parity: 8 ones -> 0.
        send16(16'h13F1, 1'b0, 1'b0, 1'b0);
        settle(1'b1);
        checks++; if (if16.data_out !== 16'h13F1 || if16.parity_err !== 1'b0) begin errors++; $display("FAIL pf0: got d=%h p=%b expected 13f1 0", if16.data_out, if16.parity_err); end
        send16(16'h0001, 1'b0, 1'b0, 1'b0);
        settle(1'b1);
        checks++; if (if16.data_out !== 16'h0001 || if16.parity_err !== 1'b1) begin errors++; $display("FAIL pf0_bad: got d=%h p=%b expected 0001 1", if16.data_out, if16.parity_err); end
    endtask

    task automatic test_back_to_back;
        if8.ready_in = 1'b0;
        send8(8'hA5, 1'b0, 1'b1);
        send8(8'h3C, 1'b0, 1'b1);
        checks++; if (if8.overrun !== 1'b0 || if8.valid_out !== 1'b1) begin errors++; $display("FAIL b2b_first: got o=%b v=%b expected 0 1", if8.overrun, if8.valid_out); end
        settle(1'b0);
        checks++; if (if8.overrun !== 1'b1) begin errors++; $display("FAIL b2b_overrun: got %b expected 1", if8.overrun); end
        checks++; if (if8.data_out !== 8'hA5 || if8.valid_out !== 1'b1) begin errors++; $display("FAIL b2b_hold: got d=%h v=%b expected a5 1", if8.data_out, if8.valid_out); end
        @(negedge clk);
        checks++; if (if8.overrun !== 1'b0) begin errors++; $display("FAIL b2b_pulse_len: got %b expected 0", if8.overrun); end
        checks++; if (if8.data_out !== 8'hA5 || if8.valid_out !== 1'b1) begin errors++; $display("FAIL b2b_hold2: got d=%h v=%b expected a5 1", if8.data_out, if8.valid_out); end
        if8.ready_in = 1'b1;
        @(negedge clk);
        checks++; if (if8.valid_out !== 1'b0) begin errors++; $display("FAIL b2b_accept: got %b expected 0", if8.valid_out); end
    endtask

    task automatic test_reset_mid;
        logic [7:0] d;
        d = 8'h5A;
        drv(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drv(1'b0, d[i]);
        repeat (SYNC_LAT + 1) @(negedge clk);
        checks++; if (if8.busy !== 1'b1) begin errors++; $display("FAIL rmid_busy_before: got %b expected 1", if8.busy); end
        reset = 1'b0;
        #1;
        checks++; if (if8.data_out !== 8'h00 || if8.valid_out !== 1'b0) begin errors++; $display("FAIL rmid_out: got d=%h v=%b expected 00 0", if8.data_out, if8.valid_out); end
        checks++; if (if8.busy !== 1'b0 || if8.overrun !== 1'b0 || if8.parity_err !== 1'b0 || if8.frame_err !== 1'b0) begin errors++; $display("FAIL rmid_flags: got b=%b o=%b p=%b f=%b expected 0 0 0 0", if8.busy, if8.overrun, if8.parity_err, if8.frame_err); end
        @(negedge clk);
        if8.Rx = 1'b1;
        reset = 1'b1;
        repeat (SYNC_LAT + 2) @(negedge clk);
        checks++; if (if8.valid_out !== 1'b0 || if8.busy !== 1'b0) begin errors++; $display("FAIL rmid_no_partial: got v=%b b=%b expected 0 0", if8.valid_out, if8.busy); end
        send8(d, 1'b0, 1'b1);
        settle(1'b0);
        checks++; if (if8.data_out !== 8'h5A || if8.valid_out !== 1'b1) begin errors++; $display("FAIL rmid_next: got d=%h v=%b expected 5a 1", if8.data_out, if8.valid_out); end
        checks++; if (if8.parity_err !== 1'b0 || if8.frame_err !== 1'b0) begin errors++; $display("FAIL rmid_next_errs: got p=%b f=%b expected 0 0", if8.parity_err, if8.frame_err); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_parity_err();
        test_frame_err();
        test_pf_groups();
        test_back_to_back();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
